// File: rtl/axi_scratchpad_responder.sv
// axi_scratchpad_responder: AXI4 subordinate backed by a word-addressed scratchpad
// with independent single-burst read and write engines.
module axi_scratchpad_responder #(
  parameter int            AW        = 64,
  parameter int            DW        = 64,
  parameter int            IW        = 8,
  parameter int            DEPTH     = 1024,
  parameter logic [AW-1:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [IW-1:0]   aw_id_i,
  input  logic [AW-1:0]   aw_addr_i,
  input  logic [7:0]      aw_len_i,
  input  logic            aw_valid_i,
  output logic            aw_ready_o,
  input  logic [DW-1:0]   w_data_i,
  input  logic [DW/8-1:0] w_strb_i,
  input  logic            w_last_i,
  input  logic            w_valid_i,
  output logic            w_ready_o,
  output logic [IW-1:0]   b_id_o,
  output logic [1:0]      b_resp_o,
  output logic            b_valid_o,
  input  logic            b_ready_i,
  input  logic [IW-1:0]   ar_id_i,
  input  logic [AW-1:0]   ar_addr_i,
  input  logic [7:0]      ar_len_i,
  input  logic            ar_valid_i,
  output logic            ar_ready_o,
  output logic [IW-1:0]   r_id_o,
  output logic [DW-1:0]   r_data_o,
  output logic [1:0]      r_resp_o,
  output logic            r_last_o,
  output logic            r_valid_o,
  input  logic            r_ready_i
);
  localparam int SB = $clog2(DW/8);
  localparam int LW = $clog2(DEPTH);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  logic [DW-1:0] mem [DEPTH];
  function automatic logic [AW-1:0] word_idx(input logic [AW-1:0] a);
    return (a - BASE_ADDR) >> SB;
  endfunction
  w_state_t      w_state, w_next;
  logic [AW-1:0] w_idx, w_addr;
  logic          w_under, w_dec, w_fire, w_in, w_en;
  logic [7:0]    w_len;
  logic [8:0]    w_cnt;
  assign aw_ready_o = w_state == W_IDLE;
  assign w_ready_o  = w_state == W_DATA;
  assign b_valid_o  = w_state == W_RESP;
  assign w_fire     = w_ready_o && w_valid_i;
  assign w_addr     = w_idx + AW'(w_cnt);
  assign w_in       = !w_under && w_addr < AW'(DEPTH);
  assign w_en       = w_fire && w_in && w_cnt <= {1'b0, w_len};
  always_comb begin
    w_next = w_state;
    if (w_state == W_IDLE && aw_valid_i) w_next = W_DATA;
    if (w_fire && w_last_i) w_next = W_RESP;
    if (b_valid_o && b_ready_i) w_next = W_IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) w_state <= W_IDLE;
    else w_state <= w_next;
  // Counter saturates past 255 so runaway bursts still read as a length mismatch.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      b_id_o   <= '0;
      b_resp_o <= 2'b00;
      w_idx    <= '0;
      w_under  <= 1'b0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_dec    <= 1'b0;
    end else begin
      if (aw_ready_o && aw_valid_i) begin
        b_id_o  <= aw_id_i;
        w_idx   <= word_idx(aw_addr_i);
        w_under <= aw_addr_i < BASE_ADDR;
        w_len   <= aw_len_i;
        w_cnt   <= '0;
        w_dec   <= 1'b0;
      end
      if (w_fire) begin
        w_cnt <= w_cnt[8] ? w_cnt : w_cnt + 9'd1;
        w_dec <= w_dec || (w_cnt <= {1'b0, w_len} && !w_in);
        if (w_last_i)
          b_resp_o <= w_cnt != {1'b0, w_len} ? 2'b10 :
                      (w_dec || !w_in) ? 2'b11 : 2'b00;
      end
    end
  always_ff @(posedge clk_i)
    if (w_en)
      for (int i = 0; i < DW/8; i++)
        if (w_strb_i[i]) mem[w_addr[LW-1:0]][8*i +: 8] <= w_data_i[8*i +: 8];
  r_state_t      r_state, r_next;
  logic [AW-1:0] r_idx, r_nidx;
  logic          r_under, r_nunder, r_in, ar_fire, r_fire, r_load;
  logic [7:0]    r_len, r_cnt;
  assign ar_ready_o = r_state == R_IDLE;
  assign r_valid_o  = r_state == R_DATA;
  assign ar_fire    = ar_ready_o && ar_valid_i;
  assign r_fire     = r_valid_o && r_ready_i;
  assign r_load     = ar_fire || (r_fire && !r_last_o);
  assign r_nidx     = ar_fire ? word_idx(ar_addr_i) : r_idx + AW'(r_cnt) + AW'(1);
  assign r_nunder   = ar_fire ? ar_addr_i < BASE_ADDR : r_under;
  assign r_in       = !r_nunder && r_nidx < AW'(DEPTH);
  always_comb begin
    r_next = r_state;
    if (ar_fire) r_next = R_DATA;
    if (r_fire && r_last_o) r_next = R_IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= R_IDLE;
    else r_state <= r_next;
  // Beat data is fetched at the edge that accepts the previous beat, so a same-edge write is not seen.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_id_o   <= '0;
      r_data_o <= '0;
      r_resp_o <= 2'b00;
      r_last_o <= 1'b0;
      r_idx    <= '0;
      r_under  <= 1'b0;
      r_len    <= '0;
      r_cnt    <= '0;
    end else begin
      if (ar_fire) begin
        r_id_o   <= ar_id_i;
        r_idx    <= r_nidx;
        r_under  <= r_nunder;
        r_len    <= ar_len_i;
        r_cnt    <= '0;
        r_last_o <= ar_len_i == 8'd0;
      end
      if (r_load) begin
        r_data_o <= r_in ? mem[r_nidx[LW-1:0]] : '0;
        r_resp_o <= r_in ? 2'b00 : 2'b11;
      end
      if (r_fire) begin
        r_cnt    <= r_cnt + 8'd1;
        r_last_o <= !r_last_o && (r_cnt + 8'd1 == r_len);
      end
    end
endmodule

// File: tb/tb_axi_scratchpad_responder.sv
// tb_axi_scratchpad_responder: directed stimulus with expected B/R responses queued
// at issue time and checked by independent handshake monitors.
module tb_axi_scratchpad_responder;
  logic        clk = 1'b0, rst_n;
  logic [7:0]  aw_id, ar_id, b_id, r_id, aw_len, ar_len, w_strb;
  logic [63:0] aw_addr, ar_addr, w_data, r_data;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [1:0]  b_resp, r_resp;
  int          checks = 0, passed = 0;
  logic [9:0]  bq[$];
  logic [74:0] rq[$];
  logic        hv = 1'b0;
  logic [74:0] held;

  axi_scratchpad_responder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_id_o(b_id), .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last), .r_valid_o(r_valid), .r_ready_i(r_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h, expected %0h", n, a, e);
  endtask

  task automatic fail(input string n, input string why);
    checks++;
    $display("FAIL %s: %s", n, why);
  endtask

  task automatic exp_b(input logic [7:0] id, input logic [1:0] resp);
    bq.push_back({id, resp});
  endtask

  task automatic exp_r(input logic [7:0] id, input logic [63:0] d, input logic [1:0] resp, input logic last);
    rq.push_back({id, d, resp, last});
  endtask

  always @(negedge clk) begin
    logic [9:0]  eb;
    logic [74:0] er;
    if (!rst_n) hv = 1'b0;
    else begin
      if (b_valid && b_ready) begin
        if (bq.size() == 0) fail("b_resp", "unexpected response");
        else begin
          eb = bq.pop_front();
          check("b_resp", {b_id, b_resp}, eb);
        end
      end
      if (r_valid && r_ready) begin
        if (rq.size() == 0) fail("r_beat", "unexpected beat");
        else begin
          er = rq.pop_front();
          check("r_beat", {r_id, r_data, r_resp, r_last}, er);
        end
      end
      if (hv) check("r_stall_hold", {r_id, r_data, r_resp, r_last}, held);
      hv = r_valid && !r_ready;
      held = {r_id, r_data, r_resp, r_last};
    end
  end

  task automatic send_aw(input logic [7:0] id, input logic [63:0] a, input logic [7:0] l);
    int t = 0;
    aw_id = id; aw_addr = a; aw_len = l; aw_valid = 1'b1;
    @(negedge clk);
    while (!aw_ready && t < 50) begin @(negedge clk); t++; end
    if (t == 50) fail("aw_handshake", "timed out");
    @(posedge clk); #1 aw_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [63:0] a, input logic [7:0] l);
    int t = 0;
    ar_id = id; ar_addr = a; ar_len = l; ar_valid = 1'b1;
    @(negedge clk);
    while (!ar_ready && t < 50) begin @(negedge clk); t++; end
    if (t == 50) fail("ar_handshake", "timed out");
    @(posedge clk); #1 ar_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    int t = 0;
    w_data = d; w_strb = s; w_last = l; w_valid = 1'b1;
    @(negedge clk);
    while (!w_ready && t < 50) begin @(negedge clk); t++; end
    if (t == 50) fail("w_handshake", "timed out");
    @(posedge clk); #1 w_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int t = 0;
    while ((bq.size() != 0 || rq.size() != 0 || !aw_ready || !ar_ready) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t == 200) fail("idle", "timed out waiting for responses");
  endtask

  initial begin
    rst_n = 1'b0;
    {aw_id, aw_addr, aw_len, aw_valid, w_data, w_strb, w_last, w_valid} = '0;
    {ar_id, ar_addr, ar_len, ar_valid} = '0;
    b_ready = 1'b1; r_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last}, 6'b110000);
    check("rst_data", {r_data, r_resp, b_resp, b_id, r_id}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // single write then read of word 2
    exp_b(8'd1, 2'b00);
    send_aw(8'd1, 64'h8000_0010, 8'd0);
    check("w_ready_after_aw", w_ready, 1'b1);
    send_w(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
    check("b_valid_after_last", b_valid, 1'b1);
    wait_idle();
    exp_r(8'd2, 64'h1122_3344_5566_7788, 2'b00, 1'b1);
    send_ar(8'd2, 64'h8000_0010, 8'd0);
    check("r_valid_after_ar", r_valid, 1'b1);
    wait_idle();

    // partial strobe on word 3
    exp_b(8'd3, 2'b00);
    send_aw(8'd3, 64'h8000_0018, 8'd0);
    send_w({64{1'b1}}, 8'hFF, 1'b1);
    exp_b(8'd4, 2'b00);
    send_aw(8'd4, 64'h8000_0018, 8'd0);
    send_w(64'h0, 8'h0F, 1'b1);
    exp_r(8'd5, 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1);
    send_ar(8'd5, 64'h8000_0018, 8'd0);
    wait_idle();

    // 4-beat burst at word 32, read back with stalls
    exp_b(8'd6, 2'b00);
    send_aw(8'd6, 64'h8000_0100, 8'd3);
    for (int i = 0; i < 4; i++) send_w(64'hA000_0000_0000_0000 | 64'(i), 8'hFF, i == 3);
    wait_idle();
    for (int i = 0; i < 4; i++) exp_r(8'd7, 64'hA000_0000_0000_0000 | 64'(i), 2'b00, i == 3);
    send_ar(8'd7, 64'h8000_0100, 8'd3);
    for (int i = 0; i < 20 && rq.size() > 0; i++) begin
      r_ready = (i % 2 == 0);
      @(posedge clk); #1;
    end
    r_ready = 1'b1;
    wait_idle();

    // burst crossing the end of the memory
    exp_b(8'd9, 2'b00);
    send_aw(8'd9, 64'h8000_0000, 8'd1);
    send_w(64'hC0C0_C0C0_C0C0_C0C0, 8'hFF, 1'b0);
    send_w(64'hC1C1_C1C1_C1C1_C1C1, 8'hFF, 1'b1);
    exp_b(8'd8, 2'b11);
    send_aw(8'd8, 64'h8000_1FF0, 8'd3);
    for (int i = 0; i < 4; i++) send_w(64'hE000_0000_0000_0000 | 64'(i), 8'hFF, i == 3);
    wait_idle();
    exp_r(8'd10, 64'hE000_0000_0000_0000, 2'b00, 1'b0);
    exp_r(8'd10, 64'hE000_0000_0000_0001, 2'b00, 1'b0);
    exp_r(8'd10, 64'h0, 2'b11, 1'b0);
    exp_r(8'd10, 64'h0, 2'b11, 1'b1);
    send_ar(8'd10, 64'h8000_1FF0, 8'd3);
    wait_idle();
    exp_r(8'd11, 64'hC0C0_C0C0_C0C0_C0C0, 2'b00, 1'b0);
    exp_r(8'd11, 64'hC1C1_C1C1_C1C1_C1C1, 2'b00, 1'b1);
    send_ar(8'd11, 64'h8000_0000, 8'd1);
    wait_idle();

    // early last on beat 1 of a len=3 burst
    exp_b(8'd12, 2'b10);
    send_aw(8'd12, 64'h8000_0200, 8'd3);
    send_w(64'hF0F0_0000_0000_0000, 8'hFF, 1'b0);
    send_w(64'hF1F1_0000_0000_0000, 8'hFF, 1'b1);
    wait_idle();
    exp_r(8'd13, 64'hF0F0_0000_0000_0000, 2'b00, 1'b0);
    exp_r(8'd13, 64'hF1F1_0000_0000_0000, 2'b00, 1'b1);
    send_ar(8'd13, 64'h8000_0200, 8'd1);
    wait_idle();

    // missing last on a len=0 burst: second beat must not land in word 97
    exp_b(8'd16, 2'b00);
    send_aw(8'd16, 64'h8000_0308, 8'd0);
    send_w(64'h4848_4848_4848_4848, 8'hFF, 1'b1);
    exp_b(8'd14, 2'b10);
    send_aw(8'd14, 64'h8000_0300, 8'd0);
    send_w(64'h6060_6060_6060_6060, 8'hFF, 1'b0);
    send_w(64'h6161_6161_6161_6161, 8'hFF, 1'b1);
    wait_idle();
    exp_r(8'd15, 64'h6060_6060_6060_6060, 2'b00, 1'b0);
    exp_r(8'd15, 64'h4848_4848_4848_4848, 2'b00, 1'b1);
    send_ar(8'd15, 64'h8000_0300, 8'd1);
    wait_idle();

    // concurrent AW and AR to word 2: read sees the old value
    exp_b(8'd17, 2'b00);
    exp_r(8'd18, 64'h1122_3344_5566_7788, 2'b00, 1'b1);
    fork
      send_aw(8'd17, 64'h8000_0010, 8'd0);
      send_ar(8'd18, 64'h8000_0010, 8'd0);
    join
    send_w(64'h9999_AAAA_BBBB_CCCC, 8'hFF, 1'b1);
    wait_idle();
    exp_r(8'd19, 64'h9999_AAAA_BBBB_CCCC, 2'b00, 1'b1);
    send_ar(8'd19, 64'h8000_0010, 8'd0);
    wait_idle();

    // reset in the middle of a stalled read burst
    r_ready = 1'b0;
    send_ar(8'd20, 64'h8000_0100, 8'd3);
    check("r_valid_stalled", r_valid, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("r_valid_async_reset", {r_valid, r_last}, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk) begin rst_n = 1'b1; r_ready = 1'b1; end
    @(posedge clk); #1;
    check("ready_after_reset", {aw_ready, ar_ready, r_valid, w_ready, b_valid}, 5'b11000);
    exp_r(8'd21, 64'hA000_0000_0000_0000, 2'b00, 1'b1);
    send_ar(8'd21, 64'h8000_0100, 8'd0);
    wait_idle();

    check("b_queue_drained", bq.size(), 0);
    check("r_queue_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
